// File: rtl/valve_sequencer.sv
// Valve sequencer: fetches 13-bit instructions from a synchronous-read store
// and drives 8 valves. Optional build macro: VALVE_SEQ_LOOP_EN (restart program on count end).
module valve_sequencer #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned MEM_DEPTH = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  instr_count,
  output logic [6:0]  rd_addr,
  input  logic [12:0] rd_data,
  output logic [7:0]  valves,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]  DEPTH8 = 8'(MEM_DEPTH);

  localparam logic [1:0] OP_SETV = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT} state_t;

  state_t        r_state;
  logic [6:0]    r_pc;
  logic [7:0]    r_count;
  logic [6:0]    r_rd_addr;
  logic [7:0]    r_valves;
  logic          r_busy;
  logic          r_done;
  logic [PW-1:0] r_presc;
  logic [10:0]   r_dwell;

  logic [7:0]  w_eff;
  logic [7:0]  w_pc_inc;
  logic [1:0]  w_op;
  logic [10:0] w_arg;
  logic        w_tick;
  logic        w_advance;
  logic        w_end;
  logic [6:0]  w_next_pc;

  assign w_eff    = ({1'b0, instr_count} < DEPTH8) ? {1'b0, instr_count} : DEPTH8;
  assign w_pc_inc = {1'b0, r_pc} + 8'd1;
  assign w_op     = rd_data[12:11];
  assign w_arg    = rd_data[10:0];
  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));

  // Instruction retires: SETV/NOP/zero-length WAIT from EXEC, or last tick of a dwell.
  assign w_advance = ((r_state == S_EXEC) && (w_op != OP_HALT) &&
                      !((w_op == OP_WAIT) && (w_arg != 11'd0))) ||
                     ((r_state == S_WAIT) && w_tick && (r_dwell == 11'd1));

  // End-of-count either finishes the run or wraps to address 0.
  always_comb begin
    w_end     = (w_pc_inc == r_count);
    w_next_pc = 7'(w_pc_inc);
`ifdef VALVE_SEQ_LOOP_EN
    if (w_end) begin
      w_end     = 1'b0;
      w_next_pc = 7'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= 7'd0;
      r_count   <= 8'd0;
      r_rd_addr <= 7'd0;
      r_valves  <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_presc   <= '0;
      r_dwell   <= 11'd0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_valves <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_count <= w_eff;
              if (w_eff == 8'd0) begin
                r_done <= 1'b1;
              end else begin
                r_state   <= S_FETCH;
                r_busy    <= 1'b1;
                r_pc      <= 7'd0;
                r_rd_addr <= 7'd0;
              end
            end
          end
          S_FETCH: r_state <= S_EXEC;
          S_EXEC: begin
            if (w_op == OP_SETV) begin
              r_valves <= rd_data[7:0];
            end else if ((w_op == OP_WAIT) && (w_arg != 11'd0)) begin
              r_state <= S_WAIT;
              r_presc <= '0;
              r_dwell <= w_arg;
            end else if (w_op == OP_HALT) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (w_tick) begin
              r_presc <= '0;
              r_dwell <= r_dwell - 11'd1;
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_advance) begin
          if (w_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_FETCH;
            r_pc      <= w_next_pc;
            r_rd_addr <= w_next_pc;
          end
        end
      end
    end
  end

  assign rd_addr = r_rd_addr;
  assign valves  = r_valves;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: doc/valve_sequencer.md
VALVE_SEQUENCER -- requirements
Module: valve_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clock cycles per WAIT tick (1 ms at 100 MHz); legal range >=1.
REQ-002 Parameter MEM_DEPTH, default 100, instruction store depth; legal range 1..128.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run the stored program from address 0.
REQ-006 stop  input  1  abort request; highest priority after rst.
REQ-007 instr_count  input  7  number of valid 13-bit instructions stored in the instruction store.
REQ-008 rd_addr  output  7  read address into the instruction store.
REQ-009 rd_data  input  13  instruction word; valid one cycle after rd_addr is presented (synchronous read).
REQ-010 valves  output  8  registered valve drive, 1 = open.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse at program completion.

Function
REQ-013 Instruction format: [12:11] opcode; 00 SETV (valves <= [7:0]); 01 WAIT (dwell [10:0] ticks); 10 NOP; 11 HALT.
REQ-014 States: IDLE, FETCH, EXEC, WAIT; 7-bit program counter pc.
REQ-015 IDLE: start=1 with effective count >0 -> FETCH with pc=0; start with effective count 0 -> done pulse next cycle, stay IDLE, valves unchanged.
REQ-016 Effective count = min(instr_count, MEM_DEPTH); instr_count is sampled when start is accepted and held for the run.
REQ-017 FETCH: rd_addr = pc; next state EXEC unconditionally.
REQ-018 EXEC: decode rd_data; SETV updates valves at the end of EXEC; NOP changes nothing; each takes 2 cycles total (FETCH + EXEC).
REQ-019 WAIT opcode with N=0 behaves as NOP; with N>0 it enters the WAIT state and stays there exactly N*TICK_DIV cycles before advancing.
REQ-020 The tick prescaler restarts at WAIT entry; tick counting is never shared across instructions.
REQ-021 Advance: pc+1; if pc+1 = effective count -> end of program (REQ-023), else FETCH.
REQ-022 HALT in EXEC -> end of program immediately; valves retain their last value.
REQ-023 End of program: done pulses for one cycle while returning to IDLE; valves hold their last value.
REQ-024 start while busy is ignored.
REQ-025 stop in any non-IDLE state: valves <= 0 next edge, IDLE, no done pulse; stop in IDLE clears valves to 0.
REQ-026 Simultaneous start and stop in IDLE: stop wins; run not started.
REQ-027 rd_addr holds its last value outside FETCH; rd_data is ignored outside EXEC.

Reset
REQ-028 rst asserted: state IDLE, pc 0, rd_addr 0, valves 0, busy 0, done 0, prescaler and dwell counters 0, independent of clk.
REQ-029 Reset mid-run abandons the run; no done pulse is produced after reset release.

Configuration
REQ-030 Macro VALVE_SEQ_LOOP_EN: when defined, end of program by count (not HALT) returns to FETCH at pc=0 without a done pulse and repeats until stop or HALT; when undefined, end of program behaves per REQ-023.

Verification
REQ-031 TICK_DIV=4; program {SETV 0xA5, WAIT 3, SETV 0x0F}, count 3, start -> valves=0xA5 at cycle 2, held 12 WAIT cycles, then 0x0F, done pulse once, busy low.
REQ-032 count=0, start -> done pulse next cycle, busy stays 0, valves unchanged.
REQ-033 Program {SETV 0xFF, WAIT 100}, stop asserted during WAIT -> valves=0x00 next edge, IDLE, no done pulse.
REQ-034 Program {SETV 0x01, HALT, SETV 0x02}, count 3 -> valves end at 0x01, done pulse, rd_addr never equals 2.
REQ-035 rst pulsed asynchronously mid-WAIT -> all outputs 0 immediately; a subsequent start runs the program from pc=0.
REQ-036 With VALVE_SEQ_LOOP_EN defined, program {SETV 0x03, SETV 0x0C}, count 2 -> valves alternate 0x03/0x0C every 2 cycles, no done pulse, until stop -> 0x00.
